// File: rtl/cel_pix_decoder.sv
// Cel pixel decoder: maps coded pixels through a 32x16 PLUT to RGB555+flag pixels and loads the PLUT from DMA.
// Optional statistics counters are built when PIX_STATS_EN is defined.
module cel_pix_decoder #(
    parameter int PLUT_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [2:0]  bpp_i,
    input  logic [4:0]  plut_hi_i,
    input  logic        bgnd_i,
    input  logic        plut_start_i,
    input  logic [31:0] plut_din_i,
    output logic        plut_rd_req_o,
    output logic        plut_busy_o,
    input  logic [15:0] pix_in_i,
    input  logic        pix_in_valid_i,
    input  logic        pix_in_skip_i,
    output logic        next_pix_o,
    output logic [15:0] pix_out_o,
    output logic        pix_out_transp_o,
    output logic        pix_out_valid_o,
    input  logic        pix_out_ready_i
`ifdef PIX_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_pix_o,
    output logic [CNT_W-1:0] stat_transp_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD
    } state_e;

    typedef enum logic [1:0] {
        MODE_PLUT,
        MODE_PLUT6,
        MODE_BYPASS,
        MODE_ZERO
    } mode_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  last_q, last_d;
    logic [4:0]  base_q, base_d;
    logic [4:0]  load_last;
    logic [4:0]  load_base;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        pipe_empty;

    logic [15:0] plut_mem [PLUT_DEPTH];

    logic        adv;
    logic        accept;
    logic        s1_load;
    logic        s1_v_q;
    mode_e       s1_mode_q, s1_mode_d;
    logic [4:0]  s1_idx_q, s1_idx_d;
    logic [15:0] s1_data_q;
    logic        s1_skip_q;
    logic        s1_bgnd_q;

    logic [15:0] lut_word;
    logic [15:0] pix_out_q, pix_out_d;
    logic        pix_out_transp_q, pix_out_transp_d;
    logic        pix_out_valid_q, pix_out_valid_d;

    // Load window: the table slice addressed by the low-depth modes, and last cycle (2N-1).
    always_comb begin
        load_last = 5'd31;
        load_base = 5'd0;
        case (bpp_i)
            3'd1: begin
                load_last = 5'd1;
                load_base = {plut_hi_i[4:1], 1'b0};
            end
            3'd2: begin
                load_last = 5'd3;
                load_base = {plut_hi_i[4:2], 2'b00};
            end
            3'd3: begin
                load_last = 5'd15;
                load_base = {plut_hi_i[4], 4'b0000};
            end
            default: ;
        endcase
    end

    assign pipe_empty = !s1_v_q && !pix_out_valid_q;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (plut_start_i) begin
                    last_d  = load_last;
                    base_d  = load_base;
                    cnt_d   = 5'd0;
                    state_d = pipe_empty ? ST_LOAD : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            last_q  <= 5'd0;
            base_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    // Even load cycles request a word, odd cycles write the word requested one cycle earlier.
    assign plut_busy_o   = (state_q == ST_LOAD);
    assign plut_rd_req_o = plut_busy_o && !cnt_q[0];
    assign wr_en         = plut_busy_o && cnt_q[0] && !reset_i;
    assign wr_addr       = base_q | {cnt_q[4:1], 1'b0};

    // NOTE: the table is storage, not control state, so it is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            plut_mem[wr_addr]         <= plut_din_i[31:16];
            plut_mem[wr_addr | 5'd1]  <= plut_din_i[15:0];
        end
    end

    assign adv        = !pix_out_valid_q || pix_out_ready_i;
    assign s1_load    = !s1_v_q || adv;
    assign next_pix_o = !reset_i && (state_q == ST_IDLE) && !plut_start_i && s1_load;
    assign accept     = pix_in_valid_i && next_pix_o;

    always_comb begin
        s1_idx_d  = 5'd0;
        s1_mode_d = MODE_ZERO;
        case (bpp_i)
            3'd1: begin
                s1_idx_d  = {plut_hi_i[4:1], pix_in_i[0]};
                s1_mode_d = MODE_PLUT;
            end
            3'd2: begin
                s1_idx_d  = {plut_hi_i[4:2], pix_in_i[1:0]};
                s1_mode_d = MODE_PLUT;
            end
            3'd3: begin
                s1_idx_d  = {plut_hi_i[4], pix_in_i[3:0]};
                s1_mode_d = MODE_PLUT;
            end
            3'd4: begin
                s1_idx_d  = pix_in_i[4:0];
                s1_mode_d = MODE_PLUT6;
            end
            3'd5: begin
                s1_idx_d  = pix_in_i[4:0];
                s1_mode_d = MODE_PLUT;
            end
            3'd6: s1_mode_d = MODE_BYPASS;
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_v_q <= 1'b0;
        end else if (s1_load) begin
            s1_v_q <= accept;
        end
    end

    always_ff @(posedge clock_i) begin
        if (s1_load && accept) begin
            s1_mode_q <= s1_mode_d;
            s1_idx_q  <= s1_idx_d;
            s1_data_q <= pix_in_i;
            s1_skip_q <= pix_in_skip_i;
            s1_bgnd_q <= bgnd_i;
        end
    end

    // Stage 2: table read lands in the output register; skip pixels keep the previous colour.
    always_comb begin
        lut_word         = plut_mem[s1_idx_q];
        pix_out_d        = pix_out_q;
        pix_out_transp_d = pix_out_transp_q;
        pix_out_valid_d  = pix_out_valid_q;
        if (adv) begin
            pix_out_valid_d = s1_v_q;
            if (s1_v_q) begin
                if (!s1_skip_q) begin
                    case (s1_mode_q)
                        MODE_PLUT:   pix_out_d = lut_word;
                        MODE_PLUT6:  pix_out_d = {s1_data_q[5], lut_word[14:0]};
                        MODE_BYPASS: pix_out_d = s1_data_q;
                        default:     pix_out_d = 16'h0000;
                    endcase
                end
                pix_out_transp_d = s1_skip_q || (s1_mode_q == MODE_ZERO) ||
                                   (!s1_bgnd_q && (pix_out_d[14:0] == 15'd0));
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pix_out_q        <= 16'h0000;
            pix_out_transp_q <= 1'b0;
            pix_out_valid_q  <= 1'b0;
        end else begin
            pix_out_q        <= pix_out_d;
            pix_out_transp_q <= pix_out_transp_d;
            pix_out_valid_q  <= pix_out_valid_d;
        end
    end

    assign pix_out_o        = pix_out_q;
    assign pix_out_transp_o = pix_out_transp_q;
    assign pix_out_valid_o  = pix_out_valid_q;

`ifdef PIX_STATS_EN
    logic [CNT_W-1:0] stat_pix_q;
    logic [CNT_W-1:0] stat_transp_q;

    // Counters track pixels actually handed to the writer and saturate rather than wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i || (state_q == ST_IDLE && plut_start_i)) begin
            stat_pix_q    <= '0;
            stat_transp_q <= '0;
        end else if (pix_out_valid_q && pix_out_ready_i) begin
            if (stat_pix_q != '1) begin
                stat_pix_q <= stat_pix_q + 1'b1;
            end
            if (pix_out_transp_q && (stat_transp_q != '1)) begin
                stat_transp_q <= stat_transp_q + 1'b1;
            end
        end
    end

    assign stat_pix_o    = stat_pix_q;
    assign stat_transp_o = stat_transp_q;
`endif

endmodule
